fpu_operand_unpack: RTL
=======================

FPU_OPERAND_UNPACK -- requirements
Module: fpu_operand_unpack

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, total packed operand width.
REQ-002 SHALL have parameter EXP_WIDTH, default 5, exponent field width.
REQ-003 SHALL have parameter SIG_WIDTH, default 10, stored fraction width.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream offers an operand pair.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand pair this cycle.
REQ-008 SHALL have port in_sub  input  1  operation select, 1 = subtract, 0 = add.
REQ-009 SHALL have port in_a, in_b  input  BIT_WIDTH each  packed IEEE-style operands.
REQ-010 SHALL have port out_valid  output  1  unpacked pair available.
REQ-011 SHALL have port out_ready  input  1  downstream adder accepts the pair.
REQ-012 SHALL have port out_sub  output  1  registered copy of in_sub.
REQ-013 SHALL have ports out_s1, out_s2  output  1 each  sign bits.
REQ-014 SHALL have ports out_e1, out_e2  output  EXP_WIDTH each  raw exponent fields.
REQ-015 SHALL have ports out_sig1, out_sig2  output  SIG_WIDTH+1 each  {hidden bit, fraction}.
REQ-016 SHALL have ports out_class1, out_class2  output  4 each  one-hot-or-zero {nan, inf, subnormal, zero}.
REQ-017 SHALL have port out_count  output  16  count of completed output handshakes.

Function
REQ-018 SHALL accept a pair when in_valid && in_ready, and SHALL complete one when out_valid && out_ready, on the same rising edge.
REQ-019 SHALL hold 2 entries total: one output register plus one skid register, in strict FIFO order.
REQ-020 SHALL drive in_ready directly from a flop: in_ready = skid register empty.
REQ-021 SHALL load an accepted pair into the output register when it is empty or completing this cycle; otherwise into the skid register.
REQ-022 SHALL move skid to output register on the completing edge when skid is full; the new input cannot be accepted that cycle, since in_ready = 0.
REQ-023 SHALL have latency 1 cycle, accept edge to out_valid, when empty; throughput 1 pair/cycle with out_ready held high.
REQ-024 SHALL hold all out_* data stable while out_valid && !out_ready.
REQ-025 SHALL unpack: s = op[BIT_WIDTH-1]; e = op[BIT_WIDTH-2:SIG_WIDTH]; sig = {(e != 0), op[SIG_WIDTH-1:0]}.
REQ-026 SHALL set out_e to raw e, with no subnormal exponent adjustment; the hidden bit alone marks subnormal/zero.
REQ-027 SHALL classify: zero = e==0 && f==0; subnormal = e==0 && f!=0; inf = e==all-ones && f==0; nan = e==all-ones && f!=0; normal = 4'b0000.
REQ-028 SHALL increment out_count by 1 on each output handshake, wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL ignore in_a/in_b/in_sub when in_valid is low; out_* data SHALL be don't-care but stable when out_valid is low.

Reset
REQ-030 SHALL, when reset is high at a rising edge, clear both entries: out_valid = 0, all out_* data = 0, out_count = 0, skid empty.
REQ-031 SHALL drive in_ready = 0 while reset is asserted, and in_ready = 1 from the first edge after reset deasserts.
REQ-032 SHALL, on reset mid-operation, discard buffered pairs without completing them; out_count SHALL NOT count discarded pairs.

Configuration
REQ-033 SHALL, with macro FPU_UNPACK_CLASSIFY_EN defined, compute and register out_class1/out_class2 per REQ-027.
REQ-034 SHALL, without FPU_UNPACK_CLASSIFY_EN, keep the ports but drive them constant 4'b0000, with no classification logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover: in_a=0x3C00, in_b=0x8001, in_sub=1, out_ready=1 -> next cycle out_valid=1, s1=0, e1=0x0F, sig1=0x400, s2=1, e2=0x00, sig2=0x001, class2=subnormal, out_sub=1.
REQ-036 SHALL cover: in_a=0x7C00, in_b=0x7E00 with FPU_UNPACK_CLASSIFY_EN -> class1=4'b0100 (inf), class2=4'b1000 (nan); without the macro -> both 4'b0000.
REQ-037 SHALL cover: out_ready=0, offer 3 pairs back-to-back -> 2 accepted, in_ready=0 from the edge after the 2nd accept; raise out_ready -> pairs emerge in order, 3rd accepted.
REQ-038 SHALL cover: reset pulsed with 2 pairs buffered -> out_valid=0, out_count=0, in_ready=0 during reset, 1 on the next cycle.
REQ-039 SHALL cover: 65537 handshakes at full rate -> out_count wraps to 0x0001, no bubbles in out_valid.

Source files
------------

// File: rtl/fpu_operand_unpack.sv
// Operand unpack stage ahead of the FP adder: splits two packed operands into sign/exponent/significand
// behind a two-entry skid buffer. Define FPU_UNPACK_CLASSIFY_EN to register nan/inf/subnormal/zero flags.
module fpu_operand_unpack #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned SIG_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sub,
  output logic                 out_s1,
  output logic                 out_s2,
  output logic [EXP_WIDTH-1:0] out_e1,
  output logic [EXP_WIDTH-1:0] out_e2,
  output logic [SIG_WIDTH:0]   out_sig1,
  output logic [SIG_WIDTH:0]   out_sig2,
  output logic [3:0]           out_class1,
  output logic [3:0]           out_class2,
  output logic [15:0]          out_count
);

  localparam int unsigned CNT_WIDTH = 16;

  typedef struct packed {
    logic                 sub;
    logic                 s1;
    logic [EXP_WIDTH-1:0] e1;
    logic [SIG_WIDTH:0]   sig1;
    logic                 s2;
    logic [EXP_WIDTH-1:0] e2;
    logic [SIG_WIDTH:0]   sig2;
`ifdef FPU_UNPACK_CLASSIFY_EN
    logic [3:0]           class1;
    logic [3:0]           class2;
`endif
  } entry_t;

`ifdef FPU_UNPACK_CLASSIFY_EN
  // One-hot {nan, inf, subnormal, zero}; normal numbers give all zeros.
  function automatic logic [3:0] classify(input logic [BIT_WIDTH-1:0] op);
    logic [EXP_WIDTH-1:0] e;
    logic [SIG_WIDTH-1:0] f;
    e = op[BIT_WIDTH-2:SIG_WIDTH];
    f = op[SIG_WIDTH-1:0];
    classify = 4'b0000;
    if (e == '0)      classify = (f == '0) ? 4'b0001 : 4'b0010;
    else if (e == '1) classify = (f == '0) ? 4'b0100 : 4'b1000;
  endfunction
`endif

  entry_t                 in_entry;
  entry_t                 out_q, out_n;
  entry_t                 skid_q, skid_n;
  logic                   out_valid_q, out_valid_n;
  logic                   skid_valid_q, skid_valid_n;
  logic                   in_ready_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   accept;
  logic                   complete;

  assign accept   = in_valid && in_ready_q;
  assign complete = out_valid_q && out_ready;

  // Field extraction; exponent kept raw, hidden bit set only for nonzero exponent.
  always_comb begin
    in_entry      = '0;
    in_entry.sub  = in_sub;
    in_entry.s1   = in_a[BIT_WIDTH-1];
    in_entry.e1   = in_a[BIT_WIDTH-2:SIG_WIDTH];
    in_entry.sig1 = {(in_a[BIT_WIDTH-2:SIG_WIDTH] != '0), in_a[SIG_WIDTH-1:0]};
    in_entry.s2   = in_b[BIT_WIDTH-1];
    in_entry.e2   = in_b[BIT_WIDTH-2:SIG_WIDTH];
    in_entry.sig2 = {(in_b[BIT_WIDTH-2:SIG_WIDTH] != '0), in_b[SIG_WIDTH-1:0]};
`ifdef FPU_UNPACK_CLASSIFY_EN
    in_entry.class1 = classify(in_a);
    in_entry.class2 = classify(in_b);
`endif
  end

  // Output/skid steering; an accept never coincides with a full skid since in_ready is low then.
  always_comb begin
    out_n        = out_q;
    skid_n       = skid_q;
    out_valid_n  = out_valid_q;
    skid_valid_n = skid_valid_q;
    if (complete) begin
      if (skid_valid_q) begin
        out_n        = skid_q;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_n = in_entry;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_n       = in_entry;
        out_valid_n = 1'b1;
      end else begin
        skid_n       = in_entry;
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      out_q        <= out_n;
      skid_q       <= skid_n;
      out_valid_q  <= out_valid_n;
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= !skid_valid_n;
      if (complete) count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sub   = out_q.sub;
  assign out_s1    = out_q.s1;
  assign out_e1    = out_q.e1;
  assign out_sig1  = out_q.sig1;
  assign out_s2    = out_q.s2;
  assign out_e2    = out_q.e2;
  assign out_sig2  = out_q.sig2;
  assign out_count = count_q;
`ifdef FPU_UNPACK_CLASSIFY_EN
  assign out_class1 = out_q.class1;
  assign out_class2 = out_q.class2;
`else
  assign out_class1 = 4'b0000;
  assign out_class2 = 4'b0000;
`endif

endmodule
